// File: rtl/dmem_bridge.sv
// dmem_bridge: converts the core's byte-addressed load/store requests into
// word-aligned bus transactions with lane strobes, replicated write data,
// load data realignment, a bounded wait for bus_ack, and sticky error flags.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES   = 256,
    parameter logic [31:0] ERROR_READ_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dmem_address,
    input  logic        dmem_enable,
    input  logic [31:0] dmem_write_data,
    input  logic        dmem_write_enable,
    input  logic [2:0]  dmem_write_mode,
    input  logic        dmem_read_enable,
    input  logic [2:0]  dmem_read_mode,
    output logic [31:0] dmem_read_data,
    output logic        dmem_wait,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        misaligned_error,
    output logic        bus_error,
    output logic [31:0] error_address
);

    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic [31:0] rd_data_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstrb_q;
    logic        mis_err_q;
    logic        bus_err_q;
    logic [31:0] err_addr_q;

    logic        accept_d;
    logic        legal_d;
    logic [1:0]  size_d;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;
    logic [31:0] rshift_d;

    // Decode the incoming request: size, legality, strobes and lane-replicated data.
    always_comb begin
        logic mode_ok;
        logic align_ok;
        accept_d = dmem_enable && (dmem_read_enable || dmem_write_enable);
        // A combined read+write request is treated as a store, so the write mode rules.
        if (dmem_write_enable) begin
            size_d  = dmem_write_mode[1:0];
            mode_ok = (dmem_write_mode <= 3'd2);
        end else begin
            size_d  = dmem_read_mode[1:0];
            mode_ok = !(dmem_read_mode inside {3'd3, 3'd6, 3'd7});
        end
        case (size_d)
            2'd1:    align_ok = (dmem_address[0] == 1'b0);
            2'd2:    align_ok = (dmem_address[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal_d = mode_ok && align_ok;
        case (size_d)
            2'd0: begin
                strb_d  = 4'b0001 << dmem_address[1:0];
                wdata_d = {4{dmem_write_data[7:0]}};
            end
            2'd1: begin
                strb_d  = dmem_address[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{dmem_write_data[15:0]}};
            end
            default: begin
                strb_d  = 4'b1111;
                wdata_d = dmem_write_data;
            end
        endcase
    end

    // Realign returned bus data to the latched byte offset; upper bits are zero.
    always_comb begin
        rshift_d = bus_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    rdata_d = {24'h0, rshift_d[7:0]};
            2'd1:    rdata_d = {16'h0, rshift_d[15:0]};
            default: rdata_d = bus_rdata;
        endcase
    end

    // Control FSM with registered bus outputs, load data, timeout and error tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            rd_data_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            mis_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
        end else if (state_q == IDLE) begin
            if (accept_d) begin
                if (!legal_d) begin
                    rd_data_q <= ERROR_READ_VALUE;
                    mis_err_q <= 1'b1;
                    if (!(mis_err_q || bus_err_q)) begin
                        err_addr_q <= dmem_address;
                    end
                end else begin
                    state_q     <= BUS;
                    cnt_q       <= '0;
                    addr_q      <= dmem_address;
                    size_q      <= size_d;
                    we_q        <= dmem_write_enable;
                    bus_req_q   <= 1'b1;
                    bus_we_q    <= dmem_write_enable;
                    bus_addr_q  <= {dmem_address[31:2], 2'b00};
                    bus_wdata_q <= wdata_d;
                    bus_wstrb_q <= dmem_write_enable ? strb_d : 4'b0000;
                end
            end
        end else begin
            if (bus_ack) begin
                state_q   <= IDLE;
                bus_req_q <= 1'b0;
                if (!we_q) begin
                    rd_data_q <= rdata_d;
                end
            end else if (cnt_q == CNT_LAST) begin
                state_q   <= IDLE;
                bus_req_q <= 1'b0;
                rd_data_q <= ERROR_READ_VALUE;
                bus_err_q <= 1'b1;
                if (!(mis_err_q || bus_err_q)) begin
                    err_addr_q <= addr_q;
                end
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign dmem_wait        = (state_q == BUS);
    assign dmem_read_data   = rd_data_q;
    assign bus_req          = bus_req_q;
    assign bus_we           = bus_we_q;
    assign bus_addr         = bus_addr_q;
    assign bus_wdata        = bus_wdata_q;
    assign bus_wstrb        = bus_wstrb_q;
    assign misaligned_error = mis_err_q;
    assign bus_error        = bus_err_q;
    assign error_address    = err_addr_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge (TIMEOUT_CYCLES = 4).
module tb_dmem_bridge;

    logic        clk;
    logic        reset_n;
    logic [31:0] dmem_address;
    logic        dmem_enable;
    logic [31:0] dmem_write_data;
    logic        dmem_write_enable;
    logic [2:0]  dmem_write_mode;
    logic        dmem_read_enable;
    logic [2:0]  dmem_read_mode;
    logic [31:0] dmem_read_data;
    logic        dmem_wait;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        misaligned_error;
    logic        bus_error;
    logic [31:0] error_address;

    int checks = 0;
    int errors = 0;

    dmem_bridge #(
        .TIMEOUT_CYCLES  (4),
        .ERROR_READ_VALUE(32'h0)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .dmem_address     (dmem_address),
        .dmem_enable      (dmem_enable),
        .dmem_write_data  (dmem_write_data),
        .dmem_write_enable(dmem_write_enable),
        .dmem_write_mode  (dmem_write_mode),
        .dmem_read_enable (dmem_read_enable),
        .dmem_read_mode   (dmem_read_mode),
        .dmem_read_data   (dmem_read_data),
        .dmem_wait        (dmem_wait),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_wstrb        (bus_wstrb),
        .bus_rdata        (bus_rdata),
        .bus_ack          (bus_ack),
        .misaligned_error (misaligned_error),
        .bus_error        (bus_error),
        .error_address    (error_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        dmem_enable       = 1'b0;
        dmem_read_enable  = 1'b0;
        dmem_write_enable = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] mode);
        dmem_address      = a;
        dmem_read_mode    = mode;
        dmem_read_enable  = 1'b1;
        dmem_write_enable = 1'b0;
        dmem_enable       = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] mode, input logic [31:0] d);
        dmem_address      = a;
        dmem_write_mode   = mode;
        dmem_write_data   = d;
        dmem_write_enable = 1'b1;
        dmem_read_enable  = 1'b0;
        dmem_enable       = 1'b1;
    endtask

    initial begin
        int reqcnt;
        reset_n = 1'b0;
        dmem_address = '0; dmem_write_data = '0; dmem_write_mode = '0; dmem_read_mode = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        idle_inputs();
        step(); step();
        chk("rst_req",   {31'b0, bus_req}, 32'h0);
        chk("rst_wait",  {31'b0, dmem_wait}, 32'h0);
        chk("rst_rdata", dmem_read_data, 32'h0);
        chk("rst_flags", {30'b0, misaligned_error, bus_error}, 32'h0);
        chk("rst_eaddr", error_address, 32'h0);
        chk("rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
        reset_n = 1'b1;
        step();

        // lw 0x100, ack in the third BUS cycle
        load(32'h100, 3'd2);
        step(); idle_inputs();
        chk("lw_req",   {31'b0, bus_req}, 32'h1);
        chk("lw_addr",  bus_addr, 32'h100);
        chk("lw_wstrb", {28'b0, bus_wstrb}, 32'h0);
        chk("lw_we",    {31'b0, bus_we}, 32'h0);
        chk("lw_wait1", {31'b0, dmem_wait}, 32'h1);
        step();
        chk("lw_wait2", {31'b0, dmem_wait}, 32'h1);
        step();
        chk("lw_wait3", {31'b0, dmem_wait}, 32'h1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEBABE;
        step(); bus_ack = 1'b0;
        chk("lw_wait_end", {31'b0, dmem_wait}, 32'h0);
        chk("lw_req_end",  {31'b0, bus_req}, 32'h0);
        chk("lw_data",     dmem_read_data, 32'hCAFEBABE);

        // sb 0xA5 to 0x203, immediate ack
        store(32'h203, 3'd0, 32'h0000_00A5);
        step(); idle_inputs();
        chk("sb_addr",  bus_addr, 32'h200);
        chk("sb_wstrb", {28'b0, bus_wstrb}, 32'h8);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        chk("sb_we",    {31'b0, bus_we}, 32'h1);
        chk("sb_wait",  {31'b0, dmem_wait}, 32'h1);
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        step(); bus_ack = 1'b0;
        chk("sb_wait_end", {31'b0, dmem_wait}, 32'h0);
        chk("sb_keep_rd",  dmem_read_data, 32'hCAFEBABE);

        // sh to 0x402: upper lanes, half replicated
        store(32'h402, 3'd1, 32'h1234BEEF);
        step(); idle_inputs();
        chk("sh_wstrb", {28'b0, bus_wstrb}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
        bus_ack = 1'b1;
        step(); bus_ack = 1'b0;

        // lhu 0x402 and lb 0x401 realignment
        load(32'h402, 3'd5);
        step(); idle_inputs();
        chk("lhu_addr",  bus_addr, 32'h400);
        chk("lhu_wstrb", {28'b0, bus_wstrb}, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h1234ABCD;
        step(); bus_ack = 1'b0;
        chk("lhu_data", dmem_read_data, 32'h00001234);
        load(32'h401, 3'd0);
        step(); idle_inputs();
        bus_ack = 1'b1;
        step(); bus_ack = 1'b0;
        chk("lb_data", dmem_read_data, 32'h000000AB);

        // ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step(); bus_ack = 1'b0;
        chk("idle_ack_rd",  dmem_read_data, 32'h000000AB);
        chk("idle_ack_req", {31'b0, bus_req}, 32'h0);

        // misaligned lw 0x101
        load(32'h101, 3'd2);
        step(); idle_inputs();
        chk("mis_req",   {31'b0, bus_req}, 32'h0);
        chk("mis_wait",  {31'b0, dmem_wait}, 32'h0);
        chk("mis_rd",    dmem_read_data, 32'h0);
        chk("mis_flag",  {31'b0, misaligned_error}, 32'h1);
        chk("mis_eaddr", error_address, 32'h101);
        chk("mis_berr",  {31'b0, bus_error}, 32'h0);
        // legal lw 0x104 afterwards; first error address is kept
        load(32'h104, 3'd2);
        step(); idle_inputs();
        chk("lw104_req", {31'b0, bus_req}, 32'h1);
        bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
        step(); bus_ack = 1'b0;
        chk("lw104_data",  dmem_read_data, 32'h55AA55AA);
        chk("lw104_eaddr", error_address, 32'h101);
        // illegal read mode 3 on an aligned address
        load(32'h108, 3'd3);
        step(); idle_inputs();
        chk("mode3_req",   {31'b0, bus_req}, 32'h0);
        chk("mode3_eaddr", error_address, 32'h101);
        chk("mode3_flag",  {31'b0, misaligned_error}, 32'h1);

        // restore a nonzero read value, then timeout with no ack
        load(32'h10C, 3'd2);
        step(); idle_inputs();
        bus_ack = 1'b1; bus_rdata = 32'h0F0F0F0F;
        step(); bus_ack = 1'b0;
        load(32'h200, 3'd2);
        step(); idle_inputs();
        reqcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_req) reqcnt++;
            step();
        end
        chk("to_reqcnt", 32'(reqcnt), 32'd4);
        chk("to_berr",   {31'b0, bus_error}, 32'h1);
        chk("to_rd",     dmem_read_data, 32'h0);
        chk("to_eaddr",  error_address, 32'h101);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        step(); bus_ack = 1'b0;
        chk("to_late_rd",  dmem_read_data, 32'h0);
        chk("to_late_req", {31'b0, bus_req}, 32'h0);

        // reset asserted during the second BUS cycle
        load(32'h300, 3'd2);
        step(); idle_inputs();
        step();
        chk("rb_wait", {31'b0, dmem_wait}, 32'h1);
        reset_n = 1'b0;
        step();
        chk("rb_req",   {31'b0, bus_req}, 32'h0);
        chk("rb_wait0", {31'b0, dmem_wait}, 32'h0);
        chk("rb_addr",  bus_addr, 32'h0);
        chk("rb_wdata", bus_wdata, 32'h0);
        chk("rb_wstrb", {28'b0, bus_wstrb}, 32'h0);
        chk("rb_flags", {30'b0, misaligned_error, bus_error}, 32'h0);
        chk("rb_eaddr", error_address, 32'h0);
        reset_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        step(); bus_ack = 1'b0;
        chk("rb_late_rd",   dmem_read_data, 32'h0);
        chk("rb_late_wait", {31'b0, dmem_wait}, 32'h0);

        // normal operation after reset
        load(32'h10, 3'd2);
        step(); idle_inputs();
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        step(); bus_ack = 1'b0;
        chk("post_rd", dmem_read_data, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
